led_display_arbiter: RTL and testbench
======================================

# led_display_arbiter

Shares the 16-LED bank between several pattern sources, such as the blinker, the speed cursor and status displays. Each source asks for the bank with a request line. The arbiter grants one owner at a time, round-robin, and enforces a minimum ownership period when others are waiting. The arbiter's registered LED word drives the board LED pins directly.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `LED_W`, default 16: LED bank width.
- `HOLD_CYCLES`, default 100_000_000: minimum ownership period in clocks (1 s at 100 MHz). Must be ≥ 2.
- `clk` in, 1: 100 MHz system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `req` in, N_REQ: request level per source; a source holds it high while it wants the bank.
- `req_leds` in, N_REQ*LED_W: pattern per source; source i occupies bits [i*LED_W +: LED_W].
- `grant` out, N_REQ: one-hot current owner; all zero when idle.
- `owner` out, $clog2(N_REQ): index of the current owner; 0 when idle.
- `busy` out, 1: high when any grant is active.
- `leds` out, LED_W: registered LED drive.

## Operation
- FSM has two states:
  - IDLE: `grant`=0, `leds`=0.
  - OWNED: `grant` and `owner` are valid.
- Round-robin pointer `ptr`:
  - Resets to 0.
  - On every new grant to requester k, `ptr` becomes (k+1) mod N_REQ.
- Pick rule: the first set `req` bit searching upward from `ptr`, wrapping.
- IDLE → OWNED when any `req` is high; the pick is granted.
- In OWNED:
  - `hold_cnt` counts up from 0 and saturates at HOLD_CYCLES-1.
  - `leds` is loaded from the owner's `req_leds` slice every cycle.
- OWNED exits, in priority order:
  1. `req[owner]`=0: go to IDLE. The owner may release at any time, hold is not enforced.
  2. `hold_cnt`==HOLD_CYCLES-1 and another `req` is high: switch directly to the pick that excludes the current owner. Stay OWNED, clear `hold_cnt`, no idle cycle.
  3. Otherwise: stay.
- If the hold has expired and nobody else is requesting, the owner keeps the bank indefinitely. When a second request later appears, the switch happens on the next cycle.
- If the owner releases in the same cycle another requester becomes eligible, go to IDLE for one cycle, then grant.
- `req_leds` of non-owners is ignored.
- Reset mid-operation: all outputs clear immediately (asynchronous). `ptr`=0, `hold_cnt`=0, state IDLE.

## Timing
- Reset values: `grant`=0, `owner`=0, `busy`=0, `leds`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request to grant: `req` sampled high at edge n gives `grant`/`busy` high after edge n. `leds` shows that owner's pattern after edge n+1.
- Release to idle: `req[owner]` sampled low at edge n gives `grant`=0 after edge n. `leds`=0 after edge n.
- Hold switch: a new grant becomes visible exactly HOLD_CYCLES clocks after the previous grant became visible.
- `leds` tracks the owner's `req_leds` with 1-cycle latency.

## Configuration
- `LED_ARB_PRIO0_EN` defined: requester 0 is preemptive. When `req[0]` is high and the owner is not 0, switch to 0 on the next edge regardless of `hold_cnt`. `ptr` is not updated by a preemptive grant. Requester 0, once granted, is subject to the normal hold rules.
- `LED_ARB_PRIO0_EN` not defined: pure round-robin, and requester 0 has no special treatment.

## Structure
- Shared package `led_pkg` holds:
  - `LED_W`, `CLK_HZ` = 100_000_000.
  - typedef `arb_state_t` enum {IDLE, OWNED}.
  - typedef `led_word_t` = logic [LED_W-1:0].
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `ptr`, `mask`.
  - Outputs: `valid`, `idx`, one-hot `gnt`.
  - The arbiter uses it for both the idle pick and the masked hold-switch pick.

## Test plan
Bench configuration: N_REQ=4, HOLD_CYCLES=8, `req_leds` slice i = 16'h1111 << i.
- Reset release with `req`=0 → `grant`=0, `busy`=0, `leds`=0 for 20 cycles.
- `req`=4'b0100 from cycle 0 → `grant`=4'b0100 after 1 edge. `leds`=16'h4444 after 2 edges. `ptr`=3.
- `req`=4'b0011 held constant → grants alternate 0001, 0010, 0001, each lasting exactly 8 cycles with no idle gap.
- Owner 1 drops `req[1]` at `hold_cnt`=3 while `req[2]` is high → one IDLE cycle with `leds`=0, then `grant`=4'b0100.
- Only `req[3]` high for 50 cycles, then `req[0]` rises → switch to 0001 on the next edge, since the hold has long expired.
- Assert `rst` mid-OWNED, asynchronously between edges → outputs are 0 immediately. After deassert, `req`=4'b1000 → grants 1000 (ptr was 0). With `LED_ARB_PRIO0_EN` defined: while 3 owns at `hold_cnt`=2, raising `req[0]` gives `grant`=0001 next edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED bank arbiter.
//   LED_W       : default LED bank width
//   CLK_HZ      : system clock rate
//   arb_state_t : arbiter FSM state
//   led_word_t  : one LED bank word
package led_pkg;
  localparam int LED_W  = 16;
  localparam int CLK_HZ = 100_000_000;

  typedef enum logic {IDLE, OWNED} arb_state_t;
  typedef logic [LED_W-1:0] led_word_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr, wrapping, for the first request not excluded
// by mask.
//   req   in  N      : request bits
//   ptr   in  PW     : search start index
//   mask  in  N      : 1 = exclude this requester from the search
//   valid out 1      : a requester was found
//   idx   out PW     : index of the pick (0 when none)
//   gnt   out N      : one-hot pick (0 when none)
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          valid,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && elig[j]) begin
        valid  = 1'b1;
        idx    = PW'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin owner arbitration of a shared LED bank, with a minimum
// ownership period enforced only while someone else is waiting.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-source request level
//   req_leds  : per-source pattern, source i at [i*LED_W +: LED_W]
//   grant     : one-hot owner (0 when idle)
//   owner     : owner index (0 when idle)
//   busy      : any grant active
//   leds      : registered LED drive, owner's pattern one cycle late
// Optional feature: define LED_ARB_PRIO0_EN to make requester 0
// preempt any other owner regardless of the hold counter.
module led_display_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LED_W       = 16,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LED_W-1:0]     req_leds,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [LED_W-1:0]           leds
);
  import led_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_CYCLES);

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] grant_n;
  logic [IW-1:0]    owner_n, ptr, ptr_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [LED_W-1:0] leds_n;

  logic [LED_W-1:0] slice [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = req_leds[i*LED_W +: LED_W];
  end

  // One picker serves both cases: unmasked while idle, and with the
  // current owner masked out for the hold-expiry handover.
  logic [N_REQ-1:0] pick_mask, pick_gnt;
  logic [IW-1:0]    pick_idx, pick_nxt;
  logic             pick_valid, hold_done;

  assign pick_mask = (state == OWNED) ? grant : '0;
  assign pick_nxt  = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES-1));

  rr_pick #(.N(N_REQ), .PW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx),
    .gnt   (pick_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      leds     <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      leds     <= leds_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    leds_n  = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWNED;
          grant_n = pick_gnt;
          owner_n = pick_idx;
          ptr_n   = pick_nxt;
          hold_n  = '0;
        end
      end
      OWNED: begin
        leds_n = slice[owner];
        if (!req[owner]) begin
          // Release wins over everything; always pass through IDLE.
          state_n = IDLE;
          grant_n = '0;
          owner_n = '0;
          leds_n  = '0;
        end
`ifdef LED_ARB_PRIO0_EN
        else if (req[0] && owner != '0) begin
          // Preemptive grant leaves ptr alone.
          grant_n = N_REQ'(1);
          owner_n = '0;
          hold_n  = '0;
        end
`endif
        else if (hold_done && pick_valid) begin
          grant_n = pick_gnt;
          owner_n = pick_idx;
          ptr_n   = pick_nxt;
          hold_n  = '0;
        end else if (!hold_done) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == OWNED);
endmodule

// File: tb/tb_led_display_arbiter.sv
module tb_led_display_arbiter;
  localparam int N    = 4;
  localparam int LW   = 16;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_leds;
  logic [N-1:0]    grant;
  logic [1:0]      owner;
  logic            busy;
  logic [LW-1:0]   leds;

  led_display_arbiter #(.N_REQ(N), .LED_W(LW), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_leds (req_leds),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    int            owner;
    logic          busy;
    logic [LW-1:0] leds;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: who owns the bank, how long they have had it.
  bit            m_owned;
  int            m_own, m_ptr, m_age;
  logic [LW-1:0] m_leds;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] pat(input int i);
    logic [LW-1:0] base;
    base = 16'h1111;
    return base << i;
  endfunction

  // First requester at or above 'from' (wrapping), skipping 'excl'.
  function automatic int pick(input logic [N-1:0] r, input int from, input int excl);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (from + i) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_own = 0; m_ptr = 0; m_age = 0; m_leds = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.grant = m_owned ? (N'(1) << m_own) : '0;
    e.owner = m_owned ? m_own : 0;
    e.busy  = m_owned;
    e.leds  = m_leds;
    q.push_back(e);
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    int k;
    if (!m_owned) begin
      m_leds = '0;
      k = pick(r, m_ptr, -1);
      if (k >= 0) begin
        m_owned = 1; m_own = k; m_ptr = (k + 1) % N; m_age = 0;
      end
    end else if (!r[m_own]) begin
      m_leds = '0; m_owned = 0; m_own = 0;
    end else begin
      m_leds = pat(m_own);
      k = pick(r, m_ptr, m_own);
`ifdef LED_ARB_PRIO0_EN
      if (r[0] && m_own != 0) begin
        m_own = 0; m_age = 0;
      end else
`endif
      if (m_age >= HOLD - 1 && k >= 0) begin
        m_own = k; m_ptr = (k + 1) % N; m_age = 0;
      end else begin
        m_age++;
      end
    end
    push_exp();
  endtask

  // Drive req mid-cycle, model the next edge, return 1 time unit after it.
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  // Reset pulse between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_grant", grant, 0);
    chk("rst_async_owner", owner, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_leds", leds, 0);
    q.delete();
    model_reset();
    push_exp();
    #1 rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a registered output word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", grant, e.grant);
        chk("owner", owner, e.owner);
        chk("busy", busy, e.busy);
        chk("leds", leds, e.leds);
      end
    end
  end

  initial begin
    logic [N-1:0] rv;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) req_leds[i*LW +: LW] = pat(i);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_leds", leds, 0);
    rst = 1'b0;

    repeat (20) step(4'b0000);

    step(4'b0100);
    chk("req_to_grant", grant, 4'b0100);
    step(4'b0100);
    chk("leds_latency", leds, 16'h4444);
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    step(4'b0011);
    chk("rr_first_after_ptr3", grant, 4'b0001);
    repeat (29) step(4'b0011);
    repeat (2) step(4'b0000);

    step(4'b0010);
    repeat (3) step(4'b0110);
    step(4'b0100);
    chk("release_idle_grant", grant, 4'b0000);
    chk("release_idle_leds", leds, 16'h0000);
    step(4'b0100);
    chk("after_idle_grant", grant, 4'b0100);
    step(4'b0100);
    repeat (2) step(4'b0000);

    repeat (50) step(4'b1000);
    step(4'b1001);
    chk("expired_hold_switch", grant, 4'b0001);
    repeat (2) step(4'b0000);

    step(4'b1000);
    step(4'b1000);
    async_reset();
    step(4'b1000);
    chk("post_reset_grant", grant, 4'b1000);
    repeat (2) step(4'b1000);
    step(4'b1001);
`ifdef LED_ARB_PRIO0_EN
    chk("prio0_preempt", grant, 4'b0001);
`else
    chk("no_prio0_hold", grant, 4'b1000);
`endif
    repeat (2) step(4'b0000);

    rv = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rv[b] = ~rv[b];
      if ($urandom_range(0, 499) == 0) async_reset();
      step(rv);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
